// File: rtl/imm_pkg.sv
// Shared types for the immediate encoder.
// Format codes, datapath widths and field-width helper.
package imm_pkg;

  localparam int INSTR_W = 34;
  localparam int DATA_W  = 24;

  typedef enum logic [1:0] {
    IMM_I10  = 2'b00,
    IMM_I16  = 2'b01,
    IMM_I2   = 2'b10,
    IMM_NONE = 2'b11
  } imm_src_e;

  function automatic int unsigned field_width(input imm_src_e src);
    int unsigned w;
    w = 0;
    case (src)
      IMM_I10:  w = 10;
      IMM_I16:  w = 16;
      IMM_I2:   w = 2;
      default:  w = 0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/imm_fit_check.sv
// Immediate fit checker: field bits, field mask and range error.
// Shared with the assembler-side checker.
module imm_fit_check
  import imm_pkg::*;
(
  input  logic [DATA_W-1:0]  i_imm,
  input  imm_src_e           i_src,
  output logic [INSTR_W-1:0] o_field,
  output logic [INSTR_W-1:0] o_mask,
  output logic               o_range_err
);

  int unsigned        w_n;
  logic [INSTR_W-1:0] w_imm_ext;

  assign w_n       = field_width(i_src);
  assign w_imm_ext = INSTR_W'(i_imm);
  assign o_mask    = (INSTR_W'(1) << w_n) - INSTR_W'(1);
  assign o_field   = w_imm_ext & o_mask;

  // Fits when every bit above the field sign bit copies it.
  always_comb begin
    o_range_err = 1'b0;
    case (i_src)
      IMM_I10: o_range_err =
        !((&i_imm[DATA_W-1:9]) || !(|i_imm[DATA_W-1:9]));
      IMM_I16: o_range_err =
        !((&i_imm[DATA_W-1:15]) || !(|i_imm[DATA_W-1:15]));
      IMM_I2:  o_range_err =
        !((&i_imm[DATA_W-1:1]) || !(|i_imm[DATA_W-1:1]));
      default: o_range_err = 1'b0;
    endcase
  end

endmodule

// File: rtl/imm_field_encoder.sv
// Pipelined immediate encoder with skid-buffered output
// and a saturating range-error counter.
module imm_field_encoder
  import imm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] base_instr,
  input  logic [DATA_W-1:0]  imm,
  input  logic [1:0]         ImmSrc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instr,
  output logic               range_err,
  input  logic               clr_err,
  output logic [CNT_W-1:0]   err_count
);

  logic [INSTR_W-1:0] w_field;
  logic [INSTR_W-1:0] w_mask;
  logic [INSTR_W-1:0] w_enc;
  logic               w_err;
  logic               w_in_fire;
  logic               w_out_free;

  logic               r_out_valid;
  logic [INSTR_W-1:0] r_out_instr;
  logic               r_out_err;
  logic               r_skid_full;
  logic [INSTR_W-1:0] r_skid_instr;
  logic               r_skid_err;
  logic [CNT_W-1:0]   r_err_count;

  imm_fit_check u_fit (
    .i_imm       (imm),
    .i_src       (imm_src_e'(ImmSrc)),
    .o_field     (w_field),
    .o_mask      (w_mask),
    .o_range_err (w_err)
  );

  assign w_enc      = (base_instr & ~w_mask) | w_field;
  assign w_in_fire  = in_valid & ~r_skid_full;
  assign w_out_free = ~r_out_valid | out_ready;

  assign in_ready  = ~r_skid_full;
  assign out_valid = r_out_valid;
  assign instr     = r_out_instr;
  assign range_err = r_out_err;
  assign err_count = r_err_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_instr  <= '0;
      r_out_err    <= 1'b0;
      r_skid_full  <= 1'b0;
      r_skid_instr <= '0;
      r_skid_err   <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_full) begin
        r_out_valid <= 1'b1;
        r_out_instr <= r_skid_instr;
        r_out_err   <= r_skid_err;
        r_skid_full <= w_in_fire;
        if (w_in_fire) begin
          r_skid_instr <= w_enc;
          r_skid_err   <= w_err;
        end
      end else begin
        r_out_valid <= w_in_fire;
        if (w_in_fire) begin
          r_out_instr <= w_enc;
          r_out_err   <= w_err;
        end
      end
    end else if (w_in_fire) begin
      r_skid_full  <= 1'b1;
      r_skid_instr <= w_enc;
      r_skid_err   <= w_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_err) begin
      r_err_count <= '0;
    end else if (w_in_fire && w_err && (r_err_count != '1)) begin
      r_err_count <= r_err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_field_encoder.sv
// Randomised and directed bench for imm_field_encoder
// against an arithmetic reference model.
module tb_imm_field_encoder;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [33:0]   base_instr;
  logic [23:0]   imm;
  logic [1:0]    ImmSrc;
  logic          out_valid;
  logic          out_ready;
  logic [33:0]   instr;
  logic          range_err;
  logic          clr_err;
  logic [CW-1:0] err_count;

  always #5 clk = ~clk;

  imm_field_encoder #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .base_instr (base_instr),
    .imm        (imm),
    .ImmSrc     (ImmSrc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .instr      (instr),
    .range_err  (range_err),
    .clr_err    (clr_err),
    .err_count  (err_count)
  );

  typedef struct {
    logic [33:0] w;
    logic        e;
  } item_t;

  item_t q[$];
  int    m_cnt = 0;
  int    n_acc = 0;
  int    n_err = 0;
  int    n_chk = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Signed-range fit and modular truncation on plain integers.
  function automatic void model(input logic [33:0] b,
                                input logic [23:0] v,
                                input logic [1:0] s,
                                output logic [33:0] o,
                                output logic e);
    int     n;
    longint x, p, f;
    n = (s == 2'd0) ? 10 : (s == 2'd1) ? 16 : (s == 2'd2) ? 2 : 0;
    if (n == 0) begin
      o = b;
      e = 1'b0;
    end else begin
      x = longint'($signed(v));
      p = longint'(1) << n;
      e = (x < -(p / 2)) || (x >= p / 2);
      f = ((x % p) + p) % p;
      o = 34'((longint'(b) / p) * p + f);
    end
  endfunction

  task automatic step();
    item_t it;
    logic  fin, fout;
    @(negedge clk);
    if (!rst) begin
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (out_valid && q.size() != 0) begin
        chk("instr", 64'(instr), 64'(q[0].w));
        chk("range_err", 64'(range_err), 64'(q[0].e));
      end
    end
    fin  = in_valid & in_ready;
    fout = out_valid & out_ready;
    if (rst) begin
      q.delete();
      m_cnt = 0;
    end else begin
      if (fout && q.size() != 0) void'(q.pop_front());
      if (fin) begin
        model(base_instr, imm, ImmSrc, it.w, it.e);
        q.push_back(it);
        n_acc++;
        if (it.e && m_cnt < (1 << CW) - 1) m_cnt++;
      end
      if (clr_err) m_cnt = 0;
    end
    @(posedge clk);
    #1;
    chk("err_count", 64'(err_count), 64'(m_cnt));
  endtask

  task automatic directed(input string tag, input logic [33:0] b,
                          input logic [23:0] v, input logic [1:0] s,
                          input logic [33:0] ew, input logic ee);
    base_instr = b;
    imm        = v;
    ImmSrc     = s;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    clr_err    = 1'b0;
    step();
    in_valid = 1'b0;
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_instr"}, 64'(instr), 64'(ew));
    chk({tag, "_err"}, 64'(range_err), 64'(ee));
    step();
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    clr_err    = 1'b0;
    base_instr = '0;
    imm        = '0;
    ImmSrc     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_range_err", 64'(range_err), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);

    directed("i10_pos", 34'h0, 24'h0001FF, 2'b00, 34'h1FF, 1'b0);
    directed("i10_neg", 34'h0, 24'hFFFE00, 2'b00, 34'h200, 1'b0);
    directed("i10_ovf", 34'h0, 24'h000200, 2'b00, 34'h200, 1'b1);
    chk("cnt_0to1", 64'(err_count), 64'd1);
    directed("i2_neg", 34'h0, 24'hFFFFFE, 2'b10, 34'h2, 1'b0);
    directed("none", 34'h3FFFFFFFF, 24'h123456, 2'b11,
             34'h3FFFFFFFF, 1'b0);
    directed("i16_min", 34'h300000000, 24'hFF8000, 2'b01,
             34'h300008000, 1'b0);

    // Backpressure: only two items fit with the consumer stalled.
    n_acc     = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      base_instr = 34'(64'h2_0000_0000 | 64'(i));
      imm        = 24'($urandom);
      ImmSrc     = 2'(i);
      step();
      if (i == 1) chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    end
    chk("bp_accepted", 64'(n_acc), 64'd2);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();

    // Saturation, then clear racing an errant accept.
    clr_err = 1'b1;
    step();
    clr_err  = 1'b0;
    base_instr = '0;
    imm      = 24'h000200;
    ImmSrc   = 2'b00;
    in_valid = 1'b1;
    repeat (5) step();
    chk("cnt_saturated", 64'(err_count), 64'd3);
    clr_err = 1'b1;
    step();
    chk("cnt_clr_wins", 64'(err_count), 64'd0);
    clr_err  = 1'b0;
    in_valid = 1'b0;
    repeat (2) step();

    // Reset with both entries full and an errant item offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    imm       = 24'h800000;
    repeat (3) step();
    chk("pre_rst_full", 64'(in_ready), 64'd0);
    rst     = 1'b1;
    clr_err = 1'b0;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_cnt", 64'(err_count), 64'd0);
    chk("mid_rst_instr", 64'(instr), 64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      clr_err    = ($urandom_range(0, 31) == 0);
      base_instr = {2'($urandom), $urandom};
      ImmSrc     = 2'($urandom);
      case ($urandom_range(0, 2))
        0: imm = 24'($urandom);
        1: imm = 24'(int'($urandom_range(0, 70000)) - 35000);
        default: imm = 24'(int'($urandom_range(0, 2047)) - 1024);
      endcase
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clr_err   = 1'b0;
    repeat (3) step();
    chk("drained", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
